// File: rtl/fir_pkg.sv
// Shared FIR coefficient-path definitions:
// default sizes and the reader state encoding.
package fir_pkg;

   localparam int NTAPS_D = 64;
   localparam int AW_D    = 6;
   localparam int DW_D    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/coef_skid_fifo.sv
// Two-entry buffer between the coefficient memory and
// the MAC handshake; flush empties it in one cycle.
module coef_skid_fifo #(
   parameter int W = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
      end else if (flush) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (push) begin
            r_mem[r_wp] <= din;
            r_wp        <= ~r_wp;
         end
         if (pop) begin
            r_rp <= ~r_rp;
         end
         r_cnt <= r_cnt + 2'(push) - 2'(pop);
      end
   end

   assign dout  = r_mem[r_rp];
   assign full  = (r_cnt == 2'd2);
   assign empty = (r_cnt == 2'd0);

endmodule

// File: rtl/coef_reader.sv
// Streams NTAPS coefficients from a 1-cycle-latency memory
// to a valid/ready consumer, with abort and done pulse.
module coef_reader
   import fir_pkg::*;
#(
   parameter int NTAPS = NTAPS_D,
   parameter int AW    = AW_D,
   parameter int DW    = DW_D
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_w_en,
   input  logic [DW-1:0] mem_rdata,
   output logic          coef_valid,
   input  logic          coef_ready,
   output logic [DW-1:0] coef_data,
   output logic [AW-1:0] coef_idx,
   output logic          coef_last
);

   localparam int            FW     = DW + AW + 1;
   localparam logic [AW-1:0] LAST_A = AW'(NTAPS - 1);

   state_t        r_state;
   logic [AW-1:0] r_next;
   logic [AW-1:0] r_last;
   logic [AW-1:0] r_infl_addr;
   logic          r_infl;
   logic          r_busy;
   logic          r_done;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_issue;
   logic [1:0]    w_occ;
   logic [2:0]    w_sum;
   logic [FW-1:0] w_din;
   logic [FW-1:0] w_dout;

   assign w_occ = {w_full, ~w_full & ~w_empty};
   assign w_pop = coef_valid & coef_ready;
   // A pop this cycle frees a slot, which keeps full rate
   assign w_sum = 3'(w_occ) + 3'(r_infl) - 3'(w_pop);
   assign w_issue = (r_state == READ) & ~abort
                  & (w_sum < 3'd2);

   assign w_din = {(r_infl_addr == LAST_A),
                   r_infl_addr, mem_rdata};

   coef_skid_fifo #(
      .W(FW)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(abort),
      .push (r_infl),
      .din  (w_din),
      .pop  (w_pop),
      .dout (w_dout),
      .full (w_full),
      .empty(w_empty)
   );

   assign mem_addr   = w_issue ? r_next : r_last;
   assign mem_w_en   = 1'b0;
   assign coef_valid = ~w_empty;
   assign coef_data  = w_dout[DW-1:0];
   assign coef_idx   = w_dout[DW+AW-1:DW];
   assign coef_last  = coef_valid & w_dout[FW-1];
   assign busy       = r_busy;
   assign done       = r_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_next      <= '0;
         r_last      <= '0;
         r_infl_addr <= '0;
         r_infl      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_infl <= w_issue;
         if (w_issue) begin
            r_last      <= r_next;
            r_infl_addr <= r_next;
            if (r_next != LAST_A) begin
               r_next <= r_next + 1'b1;
            end
         end
         if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (start) begin
                     r_state <= READ;
                     r_busy  <= 1'b1;
                     r_next  <= '0;
                  end
               end
               READ: begin
                  if (w_issue && r_next == LAST_A) begin
                     r_state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (w_pop && coef_last) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_coef_reader.sv
// Directed bench for coef_reader against a memory model
// returning 16'h1000+addr one cycle after the address.
module tb_coef_reader;

   localparam int NTAPS = 64;
   localparam int AW    = 6;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic          mem_w_en;
   logic [DW-1:0] mem_rdata = '0;
   logic          coef_valid;
   logic          coef_ready = 1'b0;
   logic [DW-1:0] coef_data;
   logic [AW-1:0] coef_idx;
   logic          coef_last;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_done = 0;
   int done_cyc = 0;
   int busy_at_done = 0;
   int viol = 0;
   int q_idx [$];
   int q_data [$];
   int q_last [$];
   int q_cyc [$];

   coef_reader #(
      .NTAPS(NTAPS),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_w_en  (mem_w_en),
      .mem_rdata (mem_rdata),
      .coef_valid(coef_valid),
      .coef_ready(coef_ready),
      .coef_data (coef_data),
      .coef_idx  (coef_idx),
      .coef_last (coef_last)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      mem_rdata <= 16'h1000 + 16'(mem_addr);
   end

   // Transfer recorder and issue-budget watch
   always @(negedge clk) begin
      int pop;
      cyc++;
      pop = (coef_valid && coef_ready) ? 1 : 0;
      if (busy && int'(mem_addr) > q_idx.size() + pop + 1)
         viol++;
      if (pop == 1) begin
         q_idx.push_back(int'(coef_idx));
         q_data.push_back(int'(coef_data));
         q_last.push_back(int'(coef_last));
         q_cyc.push_back(cyc);
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
         busy_at_done = int'(busy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      q_idx.delete();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag,
                            input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
      tick();
   endtask

   task automatic chk_seq(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < q_idx.size(); i++) begin
         if (q_idx[i] != i) bad++;
         if (q_data[i] != 32'h1000 + i) bad++;
         if (q_last[i] != ((i == NTAPS - 1) ? 1 : 0))
            bad++;
      end
      chk({tag, "_count"}, 32'(q_idx.size()), 32'(NTAPS));
      chk({tag, "_order"}, 32'(bad), 32'd0);
   endtask

   task automatic wait_tap(input string tag,
                           input int tap);
      for (int i = 0; i < 200; i++) begin
         if (coef_valid && int'(coef_idx) == tap) break;
         tick();
      end
      chk(tag, 32'(coef_idx), 32'(tap));
   endtask

   initial begin
      int b2b;
      int nd0;
      int hold_bad;
      logic [DW-1:0] h_data;
      logic [AW-1:0] h_idx;

      // Reset values
      tick();
      tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(coef_valid), 0);
      chk("rst_last", 32'(coef_last), 0);
      chk("rst_data", 32'(coef_data), 0);
      chk("rst_idx", 32'(coef_idx), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wen", 32'(mem_w_en), 0);
      rst_n = 1'b1;
      tick();

      // Full-rate burst
      coef_ready = 1'b1;
      clear_q();
      pulse_start();
      chk("t1_busy", 32'(busy), 1);
      tick();
      chk("t1_valid_early", 32'(coef_valid), 0);
      tick();
      chk("t1_first_valid", 32'(coef_valid), 1);
      chk("t1_first_data", 32'(coef_data), 32'h1000);
      chk("t1_first_idx", 32'(coef_idx), 0);
      wait_done("t1_done_seen", 300);
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_busy_end", 32'(busy), 0);
      chk_seq("t1");
      b2b = (q_cyc.size() == NTAPS) ?
            q_cyc[NTAPS-1] - q_cyc[0] : -1;
      chk("t1_b2b", 32'(b2b), 32'(NTAPS - 1));
      chk("t1_done_cyc", 32'(done_cyc),
          32'((q_cyc.size() == NTAPS) ?
              q_cyc[NTAPS-1] + 1 : -1));
      chk("t1_busy_at_done", 32'(busy_at_done), 0);
      chk("t1_ndone", 32'(n_done), 1);

      // Consumer stall for 10 cycles
      clear_q();
      pulse_start();
      tick();
      tick();
      chk("t2_first_valid", 32'(coef_valid), 1);
      for (int i = 0; i < 10; i++) tick();
      coef_ready = 1'b0;
      h_data = coef_data;
      h_idx = coef_idx;
      chk("t2_frozen_idx", 32'(h_idx), 10);
      chk("t2_frozen_data", 32'(h_data), 32'h100A);
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!coef_valid || coef_data !== h_data ||
             coef_idx !== h_idx)
            hold_bad++;
      end
      chk("t2_hold", 32'(hold_bad), 0);
      coef_ready = 1'b1;
      wait_done("t2_done_seen", 300);
      chk_seq("t2");

      // Ready toggling every cycle
      clear_q();
      pulse_start();
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 400; i++) begin
            tick();
            coef_ready = ~coef_ready;
            if (done) begin
               seen = 1'b1;
               break;
            end
         end
         chk("t3_done_seen", 32'(seen), 1);
         tick();
      end
      coef_ready = 1'b1;
      chk_seq("t3");

      // Abort at tap 30, then restart
      clear_q();
      pulse_start();
      wait_tap("t4_reach30", 30);
      nd0 = n_done;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_valid_off", 32'(coef_valid), 0);
      chk("t4_busy_off", 32'(busy), 0);
      for (int i = 0; i < 5; i++) tick();
      chk("t4_no_done", 32'(n_done), 32'(nd0));
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("t4_abort_prio", 32'(busy), 0);
      clear_q();
      pulse_start();
      tick();
      tick();
      chk("t4_restart_valid", 32'(coef_valid), 1);
      chk("t4_restart_idx", 32'(coef_idx), 0);
      chk("t4_restart_data", 32'(coef_data), 32'h1000);
      wait_done("t4_done_seen", 300);
      chk_seq("t4");

      // Reset at tap 45, then start while busy
      clear_q();
      pulse_start();
      wait_tap("t5_reach45", 45);
      rst_n = 1'b0;
      tick();
      chk("t5_busy", 32'(busy), 0);
      chk("t5_done", 32'(done), 0);
      chk("t5_valid", 32'(coef_valid), 0);
      chk("t5_last", 32'(coef_last), 0);
      chk("t5_data", 32'(coef_data), 0);
      chk("t5_idx", 32'(coef_idx), 0);
      chk("t5_addr", 32'(mem_addr), 0);
      rst_n = 1'b1;
      tick();
      clear_q();
      nd0 = n_done;
      pulse_start();
      for (int i = 0; i < 5; i++) tick();
      pulse_start();
      wait_done("t5_done_seen", 300);
      for (int i = 0; i < 5; i++) tick();
      chk("t5_single_done", 32'(n_done - nd0), 1);
      chk_seq("t5");

      chk("addr_budget", 32'(viol), 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
